// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and parity-type encodings,
// used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel-request / serial-line bundle between the TX FIFO side (master)
// and the frame transmitter (slave).
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  BUSY;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      input  TX_OUT, BUSY
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      output TX_OUT, BUSY
   );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity of a DATA_WIDTH word; even parity is the plain XOR
// reduction, odd parity its inverse. Shared with the RX parity checker.
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   logic xor_all;

   assign xor_all = ^data;
   assign par_bit = (par_typ == PAR_ODD) ? ~xor_all : xor_all;

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH bits LSB-first, optional
// parity, one stop bit; one bit per CLK edge, TX_OUT and BUSY registered.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   uart_tx_frame_if.slave   bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   uart_state_e           state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  cap_par_en;
   logic                  cap_par_bit;
   logic                  par_calc;
   logic                  accept;
   logic                  tx_q, tx_nxt;
   logic                  busy_q, busy_nxt;

   assign accept = (state == IDLE) && bus.DATA_VALID;

   // Parity is resolved from the live word at acceptance so later input
   // changes cannot disturb the frame.
   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data    (bus.P_DATA),
      .par_typ (bus.PAR_TYP),
      .par_bit (par_calc)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         tx_q   <= tx_nxt;
         busy_q <= busy_nxt;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cap_data    <= '0;
         cap_par_en  <= 1'b0;
         cap_par_bit <= 1'b0;
      end else if (accept) begin
         cap_data    <= bus.P_DATA;
         cap_par_en  <= bus.PAR_EN;
         cap_par_bit <= par_calc;
      end
   end

   // NOTE: defaults at the top of each always_comb keep every path assigned,
   // so no latches are inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE:    if (bus.DATA_VALID) state_nxt = START;
         START: begin
            state_nxt = DATA;
            cnt_nxt   = '0;
         end
         DATA: begin
            if (cnt == CNT_W'(DATA_WIDTH - 1))
               state_nxt = cap_par_en ? PARITY : STOP;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         PARITY:  state_nxt = STOP;
         STOP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so the registered line
   // carries the bit belonging to that state right after the edge.
   always_comb begin
      tx_nxt   = 1'b1;
      busy_nxt = (state_nxt != IDLE);
      unique case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = cap_data[cnt_nxt];
         PARITY:  tx_nxt = cap_par_bit;
         default: tx_nxt = 1'b1;
      endcase
   end

   assign bus.TX_OUT = tx_q;
   assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table of directed frames plus
// hand-written sequences for continuous requests and mid-frame reset.
module tb_uart_tx_frame;

   localparam int DW = 8;

   logic CLK;
   logic RST;

   int total = 0;
   int bad   = 0;

   uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_frame #(.DATA_WIDTH(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // seq[k] is the expected TX_OUT just after the k-th edge from acceptance
   typedef struct {
      logic [7:0]  data;
      logic        par_en;
      logic        par_typ;
      logic        scramble;
      logic [0:11] seq;
      int          len;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      logic [0:11] got_tx;
      logic [0:11] got_busy;
      logic [0:11] exp_busy;
      bus.P_DATA     = v.data;
      bus.PAR_EN     = v.par_en;
      bus.PAR_TYP    = v.par_typ;
      bus.DATA_VALID = 1'b1;
      step();
      bus.DATA_VALID = 1'b0;
      for (int k = 0; k < 12; k++) begin
         got_tx[k]   = bus.TX_OUT;
         got_busy[k] = bus.BUSY;
         exp_busy[k] = (k < v.len);
         if (v.scramble) begin
            bus.P_DATA  = 8'($urandom);
            bus.PAR_EN  = ~bus.PAR_EN;
            bus.PAR_TYP = ~bus.PAR_TYP;
         end
         if (k < 11) step();
      end
      check({name, " tx"}, 64'(got_tx), 64'(v.seq));
      check({name, " busy"}, 64'(got_busy), 64'(exp_busy));
      step();
   endtask

   task automatic run_continuous();
      logic [7:0]  w [33];
      logic [0:32] got_tx, got_busy, exp_tx, exp_busy;
      for (int j = 0; j < 33; j++) w[j] = 8'(j * 37 + 5);
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.DATA_VALID = 1'b1;
      for (int j = 0; j < 33; j++) begin
         bus.P_DATA = w[j];
         step();
         got_tx[j]   = bus.TX_OUT;
         got_busy[j] = bus.BUSY;
      end
      bus.DATA_VALID = 1'b0;
      // frames accepted at edges 0, 11, 22: 10 busy cycles then one idle
      for (int f = 0; f < 3; f++) begin
         exp_tx[11*f]      = 1'b0;
         exp_busy[11*f]    = 1'b1;
         for (int i = 0; i < 8; i++) begin
            exp_tx[11*f+1+i]   = w[11*f][i];
            exp_busy[11*f+1+i] = 1'b1;
         end
         exp_tx[11*f+9]    = 1'b1;
         exp_busy[11*f+9]  = 1'b1;
         exp_tx[11*f+10]   = 1'b1;
         exp_busy[11*f+10] = 1'b0;
      end
      check("continuous tx", 64'(got_tx), 64'(exp_tx));
      check("continuous busy", 64'(got_busy), 64'(exp_busy));
      step();
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b0101_0010_1111, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 12'b0101_0010_1011, 11};
      vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 12'b0101_0010_1111, 11};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 12'b0000_0000_0111, 11};
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 12'b0111_1111_1011, 11};
      vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 12'b0001_1110_0111, 10};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b1, 12'b0100_0000_0011, 11};

      RST            = 1'b1;
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      step();
      check("reset tx", 64'(bus.TX_OUT), 64'(1'b1));
      check("reset busy", 64'(bus.BUSY), 64'(1'b0));
      RST = 1'b0;
      step();

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      run_continuous();

      // abort during data bit 3 of 0xA5, then send a clean frame
      bus.P_DATA     = 8'hA5;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.DATA_VALID = 1'b1;
      step();
      bus.DATA_VALID = 1'b0;
      repeat (4) step();
      check("bit3 before reset", 64'(bus.TX_OUT), 64'(1'b0));
      check("busy before reset", 64'(bus.BUSY), 64'(1'b1));
      #2 RST = 1'b1;
      #1;
      check("async reset tx", 64'(bus.TX_OUT), 64'(1'b1));
      check("async reset busy", 64'(bus.BUSY), 64'(1'b0));
      step();
      RST = 1'b0;
      step();
      run_vec(vecs[1], "after reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the UART block: the transmit-side counterpart of the UART receive path. Accepts one parallel word per frame and shifts it out LSB-first as start bit, data bits, optional parity bit and one stop bit, one bit per CLK cycle (CLK is the TX baud clock). It sits between the system's TX FIFO/synchroniser and the serial pad.

## Interface
- DATA_WIDTH, 8, data bits per frame (≥ 2)
- CLK  input  1  TX baud clock; one serial bit per rising edge
- RST  input  1  reset, asynchronous, active-high
- P_DATA  input  DATA_WIDTH  parallel word to send
- DATA_VALID  input  1  P_DATA valid this cycle; request to start a frame
- PAR_EN  input  1  1 = insert parity bit
- PAR_TYP  input  1  0 = even, 1 = odd parity
- TX_OUT  output  1  serial line, registered, idle high
- BUSY  output  1  registered; 1 while a frame is in progress

## Operation
- One clock, CLK; reset is asynchronous and active-high (RST).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. On an edge with DATA_VALID=1, capture P_DATA, PAR_EN and PAR_TYP into internal registers, compute the parity bit from the captured word, and go to START.
- START: TX_OUT=0. Next: DATA, bit counter = 0.
- DATA: TX_OUT = captured[bit counter]; counter increments each cycle. After bit DATA_WIDTH-1: go to PARITY if the captured PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = XOR of the captured word (even), inverted for odd. Next: STOP.
- STOP: TX_OUT=1. Next: IDLE.
- DATA_VALID, P_DATA, PAR_EN and PAR_TYP are ignored in every state except IDLE. Changing the inputs mid-frame has no effect.
- Requests are accepted only in IDLE, so no back-to-back frames. At least one idle cycle (TX_OUT=1, BUSY=0) separates consecutive frames.
- Bit counter width is $clog2(DATA_WIDTH). The counter never wraps inside a frame.

## Timing
- Reset values: TX_OUT=1, BUSY=0, state=IDLE, counter=0, captured regs=0.
- RST asserted mid-frame aborts immediately. The line returns to 1 with no stop bit generated. After release the block is in IDLE.
- Acceptance edge E0: after E0, TX_OUT=0 (start bit) and BUSY=1.
- Data bit i appears after edge E(1+i).
- Parity appears after E(DATA_WIDTH+1) when enabled.
- Stop bit appears after E(DATA_WIDTH+1), or after E(DATA_WIDTH+2) with parity.
- The edge after the stop cycle returns the block to IDLE with BUSY=0.
- Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity. BUSY is high for exactly that many cycles.
- A new request is accepted at the first edge where state=IDLE. Minimum request-to-request spacing is frame length + 1 cycles.

## Structure
- Shared package uart_pkg holds:
  - the state enum, also reusable by the RX FSM;
  - the constants PAR_EVEN=1'b0 and PAR_ODD=1'b1.
- One sub-module, uart_parity_calc: combinational parity of a DATA_WIDTH word for a given PAR_TYP, shared with the RX parity checker.
- Top-level RTL holds the FSM, bit counter, capture registers and output mux.

## Test plan
- Reset, then send 0xA5 with PAR_EN=0 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. BUSY high for 10 cycles, then low, TX_OUT=1.
- Send 0xA5 with PAR_EN=1, PAR_TYP=0 → parity bit 0, frame 11 cycles. Repeat with PAR_TYP=1 → parity bit 1.
- Send 0x00 with odd parity → 0, eight 0s, 1, 1. Send 0xFF with even parity → 0, eight 1s, 0, 1.
- Hold DATA_VALID=1 continuously with P_DATA changing every cycle → frames carry only the word present at each IDLE acceptance edge. Exactly one idle cycle appears between frames.
- Assert RST during data bit 3 → TX_OUT=1 and BUSY=0 immediately, asynchronously. Next request sends a complete, correct frame.
- Toggle PAR_EN/PAR_TYP mid-frame → the frame keeps the format captured at acceptance.
